// File: rtl/sram_responder_if.sv
// -----------------------------------------------------------------------------
// sram_responder_if
// Bus bundle between an SRAM requester and sram_responder.
//   sramRaddr  : read word address (requester -> responder)
//   sramWaddr  : write word address (requester -> responder)
//   sramWen    : write enable (requester -> responder)
//   sramWdata  : write data (requester -> responder)
//   sramRdata  : registered read data (responder -> requester)
//   sramReady  : initialisation complete, accesses accepted (responder -> requester)
//   oobCnt     : saturating out-of-range access count (responder -> requester)
// Modports: master = requester side, slave = responder side.
// -----------------------------------------------------------------------------
interface sram_responder_if;
    logic [31:0] sramRaddr;
    logic [31:0] sramWaddr;
    logic        sramWen;
    logic [31:0] sramWdata;
    logic [31:0] sramRdata;
    logic        sramReady;
    logic [7:0]  oobCnt;

    modport master (
        output sramRaddr, sramWaddr, sramWen, sramWdata,
        input  sramRdata, sramReady, oobCnt
    );

    modport slave (
        input  sramRaddr, sramWaddr, sramWen, sramWdata,
        output sramRdata, sramReady, oobCnt
    );
endinterface

// File: rtl/sram_responder.sv
// -----------------------------------------------------------------------------
// sram_responder
// DEPTH x 32-bit word store with a power-up clearing sweep. After reset the
// block spends exactly DEPTH cycles writing INIT_VAL to every word (INIT),
// then serves one read and one write per cycle (READY) until the next reset.
// Accesses whose address has any bit at or above log2(DEPTH) set are out of
// range: writes are dropped, reads return zero, and each one is counted in a
// saturating 8-bit counter.
//
// Parameters:
//   DEPTH    : number of 32-bit words, power of two, 16..4096
//   INIT_VAL : value written to every word by the clearing sweep
// Ports:
//   clk  : clock, all state updates on the rising edge
//   rstn : asynchronous active-low reset
//   bus  : sram_responder_if.slave (addresses, write strobe/data in;
//          read data, ready flag, out-of-range count out)
// Configuration macro:
//   SRAM_RESPONDER_BYPASS_EN : when defined, a same-cycle read and write of
//   the same in-range word returns the new write data (write-first);
//   otherwise the old contents are returned (read-first).
// -----------------------------------------------------------------------------
module sram_responder #(
    parameter int unsigned DEPTH    = 256,
    parameter logic [31:0] INIT_VAL = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rstn,
    sram_responder_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
    logic            ready_q, ready_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [7:0]      oob_q, oob_d;

    // Storage; deliberately not reset so it can map onto block RAM. Contents
    // are defined by the INIT sweep instead.
    logic [31:0]     mem [DEPTH];

    logic            mem_we;
    logic [AW-1:0]   mem_waddr;
    logic [31:0]     mem_wdata;

    logic            rd_oob;
    logic            wr_oob;
    logic [AW-1:0]   rd_idx;
    logic [AW-1:0]   wr_idx;
    logic            wr_valid;
    logic            collision;
    logic [1:0]      oob_inc;
    logic [8:0]      oob_sum;

    // Any address bit at or above AW set means the access is out of range.
    assign rd_oob    = |(bus.sramRaddr >> AW);
    assign wr_oob    = |(bus.sramWaddr >> AW);
    assign rd_idx    = bus.sramRaddr[AW-1:0];
    assign wr_idx    = bus.sramWaddr[AW-1:0];
    assign wr_valid  = bus.sramWen && !wr_oob;
    // Both addresses in range and equal low bits means the full addresses match.
    assign collision = wr_valid && !rd_oob && (wr_idx == rd_idx);

    // Only writes with the strobe high are accesses; every read slot is one.
    assign oob_inc   = {1'b0, rd_oob} + {1'b0, bus.sramWen && wr_oob};
    assign oob_sum   = {1'b0, oob_q} + {7'b0, oob_inc};

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        rdata_d   = 32'h0;
        oob_d     = oob_q;
        mem_we    = 1'b0;
        mem_waddr = wr_idx;
        mem_wdata = bus.sramWdata;

        case (state_q)
            ST_INIT: begin
                // Requester writes are ignored; the sweep owns the write port.
                mem_we    = 1'b1;
                mem_waddr = clr_cnt_q;
                mem_wdata = INIT_VAL;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == AW'(DEPTH - 1)) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                mem_we = wr_valid;
                if (!rd_oob) begin
                    rdata_d = mem[rd_idx];
`ifdef SRAM_RESPONDER_BYPASS_EN
                    if (collision) begin
                        rdata_d = bus.sramWdata;
                    end
`else
                    // Read-first: the array value sampled this edge is the
                    // pre-write contents, so a collision needs no special case.
                    if (collision) begin
                        rdata_d = mem[rd_idx];
                    end
`endif
                end
                oob_d = oob_sum[8] ? 8'hFF : oob_sum[7:0];
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase

        // Ready mirrors the registered state exactly.
        ready_d = (state_d == ST_READY);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_INIT;
            clr_cnt_q <= '0;
            ready_q   <= 1'b0;
            rdata_q   <= 32'h0;
            oob_q     <= 8'h00;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            ready_q   <= ready_d;
            rdata_q   <= rdata_d;
            oob_q     <= oob_d;
        end
    end

    // Array write port. Gating with rstn keeps edges seen while reset is held
    // from touching the array; the sweep restarts from word 0 on release.
    always_ff @(posedge clk) begin
        if (mem_we && rstn) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign bus.sramRdata = rdata_q;
    assign bus.sramReady = ready_q;
    assign bus.oobCnt    = oob_q;

endmodule

// File: tb/tb_sram_responder.sv
// -----------------------------------------------------------------------------
// tb_sram_responder
// Directed bench for sram_responder (DEPTH=256, INIT_VAL=32'hDEAD_BEEF).
// Expected read data is pushed to a scoreboard queue when each access is
// driven and popped when the registered result appears one cycle later.
// -----------------------------------------------------------------------------
module tb_sram_responder;
    localparam int unsigned DEPTH    = 256;
    localparam logic [31:0] INIT_VAL = 32'hDEAD_BEEF;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    sram_responder_if bus ();

    sram_responder #(
        .DEPTH   (DEPTH),
        .INIT_VAL(INIT_VAL)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int          checks  = 0;
    int          errors  = 0;
    int          exp_oob = 0;
    logic [31:0] mdl [DEPTH];
    logic [31:0] sb [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < int'(DEPTH); i++) mdl[i] = INIT_VAL;
        exp_oob = 0;
    endtask

    // One READY-state cycle: drive, predict, clock, compare.
    task automatic cycle(input logic [31:0] ra, input logic [31:0] wa, input logic we,
                         input logic [31:0] wd, input string tag);
        logic [31:0] e;
        int          n;
        logic [31:0] got;
        bus.sramRaddr = ra;
        bus.sramWaddr = wa;
        bus.sramWen   = we;
        bus.sramWdata = wd;
        if (ra[31:8] != 24'h0) e = 32'h0;
        else if (we && wa == ra) begin
`ifdef SRAM_RESPONDER_BYPASS_EN
            e = wd;
`else
            e = mdl[ra[7:0]];
`endif
        end else e = mdl[ra[7:0]];
        sb.push_back(e);
        n = ((ra[31:8] != 24'h0) ? 1 : 0) + ((we && wa[31:8] != 24'h0) ? 1 : 0);
        if (we && wa[31:8] == 24'h0) mdl[wa[7:0]] = wd;
        @(posedge clk);
        #1;
        exp_oob = (exp_oob + n > 255) ? 255 : exp_oob + n;
        got = sb.pop_front();
        $display("txn %s ra=%h wa=%h we=%0d wd=%h rdata=%h oob=%0d", tag, ra, wa, we, wd,
                 bus.sramRdata, bus.oobCnt);
        check(tag, bus.sramRdata, got);
        check({tag, "_oob"}, {24'h0, bus.oobCnt}, exp_oob[31:0]);
    endtask

    // Release reset and count edges until ready; drives an ignored write and
    // an out-of-range read throughout INIT.
    task automatic run_init(input int stop_at, output int n);
        rstn          = 1'b1;
        bus.sramWen   = 1'b1;
        bus.sramWaddr = 32'h3;
        bus.sramWdata = 32'h1111_1111;
        bus.sramRaddr = 32'h200;
        n = 0;
        while (n < 400 && !(stop_at > 0 && n == stop_at)) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 10) begin
                check("init_rdata", bus.sramRdata, 32'h0);
                check("init_oob", {24'h0, bus.oobCnt}, 32'h0);
            end
            if (bus.sramReady) break;
        end
        bus.sramWen = 1'b0;
        $display("txn init_run edges=%0d ready=%0d", n, bus.sramReady);
    endtask

    initial begin
        int n;
        bus.sramRaddr = 32'h0;
        bus.sramWaddr = 32'h0;
        bus.sramWen   = 1'b0;
        bus.sramWdata = 32'h0;
        model_reset();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'h0, bus.sramReady}, 32'h0);
        check("rst_rdata", bus.sramRdata, 32'h0);
        check("rst_oob", {24'h0, bus.oobCnt}, 32'h0);

        // INIT sweep latency; write to addr 3 during INIT must be ignored
        run_init(0, n);
        check("init_latency", n, 256);
        check("ready_up", {31'h0, bus.sramReady}, 32'h1);
        check("ready_oob", {24'h0, bus.oobCnt}, 32'h0);

        cycle(32'h7F, 32'h0, 1'b0, 32'h0, "rd_7f");
        cycle(32'h3, 32'h0, 1'b0, 32'h0, "rd_3_init");

        // Write then read
        cycle(32'h0, 32'h5, 1'b1, 32'h1234_5678, "wr_5");
        cycle(32'h5, 32'h0, 1'b0, 32'h0, "rd_5");

        // Same-address collision
        cycle(32'h0, 32'h9, 1'b1, 32'hAAAA_AAAA, "wr_9");
        cycle(32'h9, 32'h9, 1'b1, 32'h5555_5555, "coll_9");
        cycle(32'h9, 32'h0, 1'b0, 32'h0, "rd_9");

        // Different in-range addresses in one cycle
        cycle(32'h5, 32'hA, 1'b1, 32'h0000_CAFE, "rw_diff");
        cycle(32'hA, 32'h0, 1'b0, 32'h0, "rd_a");

        // Out-of-range pair, array unchanged
        cycle(32'h200, 32'h100, 1'b1, 32'hFFFF_0000, "oob_pair");
        cycle(32'h0, 32'h0, 1'b0, 32'h0, "rd_0_after_oob");
        cycle(32'hFF, 32'h1FF, 1'b0, 32'h0, "oob_wen0");

        // Mixed traffic
        for (int i = 0; i < 24; i++) begin
            cycle({24'h0, 8'($urandom_range(0, 31))}, {24'h0, 8'($urandom_range(0, 31))},
                  1'($urandom_range(0, 1)), $urandom, "mix");
        end

        // Saturation
        for (int i = 0; i < 200; i++) begin
            cycle(32'h200, 32'h100, 1'b1, 32'h0BAD_0BAD, "oob_sat");
        end
        check("oob_ff", {24'h0, bus.oobCnt}, 32'hFF);

        // Leave nonzero read data, then reset asynchronously
        cycle(32'h5, 32'h0, 1'b0, 32'h0, "pre_rst_rd");
        rstn = 1'b0;
        #1;
        check("async_ready", {31'h0, bus.sramReady}, 32'h0);
        check("async_oob", {24'h0, bus.oobCnt}, 32'h0);
        check("async_rdata", bus.sramRdata, 32'h0);
        model_reset();
        @(posedge clk);
        #1;

        // Abort INIT at cycle 100, then full sweep again
        run_init(100, n);
        check("mid_init_cnt", n, 100);
        rstn = 1'b0;
        #1;
        check("mid_init_ready", {31'h0, bus.sramReady}, 32'h0);
        check("mid_init_oob", {24'h0, bus.oobCnt}, 32'h0);
        @(posedge clk);
        #1;
        run_init(0, n);
        check("reinit_latency", n, 256);
        cycle(32'h5, 32'h0, 1'b0, 32'h0, "rd_5_reinit");
        cycle(32'h9, 32'h0, 1'b0, 32'h0, "rd_9_reinit");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sram_responder.md
SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
REQ-001 Parameter DEPTH, default 256, number of 32-bit words; power of two, 16..4096.
REQ-002 Parameter INIT_VAL, default 32'h0000_0000, value written to every word during initialisation.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rstn  input  1  reset, asynchronous assert, active-low.
REQ-005 sramRaddr  input  32  read word address.
REQ-006 sramWaddr  input  32  write word address.
REQ-007 sramWen  input  1  write enable, sampled each rising edge.
REQ-008 sramWdata  input  32  write data.
REQ-009 sramRdata  output  32  registered read data.
REQ-010 sramReady  output  1  high when initialisation is done and accesses are accepted.
REQ-011 oobCnt  output  8  saturating count of out-of-range accesses.

Function
REQ-012 The block SHALL hold a DEPTH x 32 storage array indexed by address bits [log2(DEPTH)-1:0].
REQ-013 An address with any bit at or above log2(DEPTH) set SHALL be out-of-range.
REQ-014 The FSM SHALL have two states: INIT and READY. INIT is the state after reset.
REQ-015 In INIT, a clear counter SHALL start at 0 and write INIT_VAL to word[counter] each cycle.
REQ-016 The FSM SHALL go from INIT to READY on the cycle after the counter writes word DEPTH-1, after exactly DEPTH cycles.
REQ-017 READY SHALL persist until reset. No other transition SHALL exist.
REQ-018 sramReady SHALL equal (state == READY), registered.
REQ-019 In INIT, sramWen SHALL be ignored, sramRdata SHALL be 0, and oobCnt SHALL not change.
REQ-020 In READY, sramRdata SHALL present word[sramRaddr], sampled at edge N, after edge N. Read latency is 1 cycle.
REQ-021 In READY with sramWen=1 at edge N and sramWaddr in range, word[sramWaddr] SHALL take sramWdata at edge N.
REQ-022 An out-of-range write SHALL be dropped; the array is unchanged.
REQ-023 An out-of-range read SHALL return 32'h0 on the following cycle.
REQ-024 Each edge in READY SHALL add the number of out-of-range accesses (read and write counted separately, 0..2) to oobCnt, saturating at 8'hFF.
REQ-025 A read and a write to different in-range addresses in the same cycle SHALL both complete with no interaction.
REQ-026 A read and a write to the same address in the same cycle SHALL follow REQ-032/REQ-033.
REQ-027 sramRdata SHALL hold its value on cycles with no new sample only as required by REQ-020; it updates every edge.

Reset
REQ-028 Asserting rstn low SHALL immediately force state=INIT, clear counter=0, sramReady=0, sramRdata=0 and oobCnt=0.
REQ-029 Reset SHALL not clear the array directly. Clearing happens through the INIT sweep after rstn deasserts.
REQ-030 Reset asserted mid-INIT or mid-write SHALL abort the operation. The sweep restarts from word 0 after release.
REQ-031 The first INIT write SHALL occur on the first rising edge with rstn high.

Configuration
REQ-032 With macro SRAM_RESPONDER_BYPASS_EN defined, a same-cycle same-address read and write SHALL return the new sramWdata on the next cycle (write-first).
REQ-033 Without SRAM_RESPONDER_BYPASS_EN, the same collision SHALL return the old array contents (read-first). All other behaviour is identical.

Verification
REQ-034 Reset, then DEPTH=256, INIT_VAL=32'hDEAD_BEEF -> sramReady rises exactly 256 cycles after rstn release; read of addr 0x7F returns 32'hDEAD_BEEF.
REQ-035 READY; write 32'h1234_5678 to addr 5, then read addr 5 next cycle -> sramRdata=32'h1234_5678 one cycle after the read address is presented.
REQ-036 Addr 9 holds 32'hAAAA_AAAA; same cycle write 32'h5555_5555 and read addr 9 -> next-cycle sramRdata is 32'h5555_5555 with SRAM_RESPONDER_BYPASS_EN, 32'hAAAA_AAAA without.
REQ-037 Write addr 0x100 and read addr 0x200 in one cycle, DEPTH=256 -> array unchanged, sramRdata=0, oobCnt increments by 2; 200 such cycles -> oobCnt=8'hFF.
REQ-038 Assert rstn at INIT cycle 100 -> sramReady=0 and oobCnt=0 at once; after release, sramReady rises after 256 more cycles.
REQ-039 sramWen=1 to addr 3 during INIT -> word 3 holds INIT_VAL after READY.
